// File: rtl/mux_sched_pkg.sv
// Shared constants and state encoding for the round-robin selector scheduler.
package mux_sched_pkg;

    localparam int unsigned N_REQ           = 4;
    localparam int unsigned SEL_W           = 2;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned HOLD_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_latch.sv
// Gated 4:1 bit selector; output forced low while not enabled.
module mux_latch
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] data,
    input  logic [SEL_W-1:0] valid,
    input  logic             flag,
    output logic             y_c
);

    assign y_c = flag & data[valid];

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        any    = |req;
        idx    = '0;
        onehot = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[SEL_W'(int'(last) + k)]) begin
                idx = SEL_W'(int'(last) + k);
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one gated selector among four requesters,
// with bounded grant length and a one-cycle switch-over bubble.
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             flag,
    output logic             out_data,
    output logic             out_valid,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   sel_d;
    logic [N_REQ-1:0]   grant_d;
    logic               flag_d;
    logic               busy_d;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   pick_onehot;
    logic               sel_bit_c;

    rr_pick4 u_pick (
        .req    (req),
        .last   (last_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    mux_latch u_sel (
        .data  (data),
        .valid (sel),
        .flag  (flag),
        .y_c   (sel_bit_c)
    );

    // Next-state and next-output logic; sel is held through GAP and IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel;
        grant_d = grant;
        flag_d  = flag;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    grant_d = pick_onehot;
                    sel_d   = pick_idx;
                    flag_d  = 1'b1;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (!req[sel] || (cnt_q == CNT_W'(HOLD_CYCLES - 1))) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                    flag_d  = 1'b0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                flag_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; out_data/out_valid trail flag by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= SEL_W'(N_REQ - 1);
            sel       <= '0;
            grant     <= '0;
            flag      <= 1'b0;
            busy      <= 1'b0;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            sel       <= sel_d;
            grant     <= grant_d;
            flag      <= flag_d;
            busy      <= busy_d;
            out_data  <= sel_bit_c;
            out_valid <= flag;
        end
    end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Randomised and directed bench for mux_rr_sched against a transaction-level model.
module tb_mux_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] data = 4'b0000;

    logic [3:0] g0, g1;
    logic [1:0] s0, s1;
    logic       f0, f1, od0, od1, ov0, ov1, b0, b1;

    int checks = 0;
    int errors = 0;

    mux_rr_sched #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .grant(g0), .sel(s0), .flag(f0), .out_data(od0), .out_valid(ov0), .busy(b0)
    );

    mux_rr_sched #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .grant(g1), .sel(s1), .flag(f1), .out_data(od1), .out_valid(ov1), .busy(b1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: owner (-1 = none), cycles granted so far, bubble cycles still owed.
    int m_owner [2];
    int m_len   [2];
    int m_cool  [2];
    int m_last  [2];
    int m_sel   [2];
    bit m_ov    [2];
    bit m_od    [2];

    function automatic int hold_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_owner[i] = -1; m_len[i] = 0; m_cool[i] = 0;
                m_last[i] = 3;   m_sel[i] = 0; m_ov[i] = 0; m_od[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ov[i] = (m_owner[i] >= 0);
                m_od[i] = m_ov[i] ? data[m_owner[i]] : 1'b0;
                if (m_owner[i] >= 0) begin
                    if (!req[m_owner[i]] || m_len[i] >= hold_of(i)) begin
                        m_owner[i] = -1;
                        m_cool[i]  = 1;
                    end else begin
                        m_len[i]++;
                    end
                end else if (m_cool[i] > 0) begin
                    m_cool[i]--;
                end else if (req != 4'b0000) begin
                    for (int k = 4; k >= 1; k--) begin
                        if (req[(m_last[i] + k) % 4]) m_owner[i] = (m_last[i] + k) % 4;
                    end
                    m_last[i] = m_owner[i];
                    m_sel[i]  = m_owner[i];
                    m_len[i]  = 1;
                end
            end
        end
    end

    task automatic cmp_dut(input int i, input logic [3:0] g, input logic [1:0] s, input logic f,
                           input logic d, input logic v, input logic b);
        logic [3:0] eg;
        eg = (m_owner[i] >= 0) ? 4'(1 << m_owner[i]) : 4'b0000;
        chk($sformatf("d%0d_grant", i), 8'(g), 8'(eg));
        chk($sformatf("d%0d_sel", i), 8'(s), 8'(m_sel[i]));
        chk($sformatf("d%0d_flag", i), 8'(f), 8'(m_owner[i] >= 0));
        chk($sformatf("d%0d_out_data", i), 8'(d), 8'(m_od[i]));
        chk($sformatf("d%0d_out_valid", i), 8'(v), 8'(m_ov[i]));
        chk($sformatf("d%0d_busy", i), 8'(b), 8'((m_owner[i] >= 0) || (m_cool[i] > 0)));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, g0, s0, f0, od0, ov0, b0);
        cmp_dut(1, g1, s1, f1, od1, ov1, b1);
    end

    logic [3:0] onset [8];
    int         n_onset;

    task automatic capture(input int which, input int n, input int budget);
        logic [3:0] prev, cur;
        prev = 4'b0000;
        n_onset = 0;
        for (int c = 0; c < budget && n_onset < n; c++) begin
            @(negedge clk);
            cur = (which == 0) ? g0 : g1;
            if (cur != 4'b0000 && prev == 4'b0000) begin
                onset[n_onset] = cur;
                n_onset++;
            end
            prev = cur;
        end
        chk("onset_count", 8'(n_onset), 8'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 8'(g0), 8'h0);
        chk("rst_busy", 8'(b0), 8'h0);
        rst_n = 1'b1;

        // Idle with no requests.
        repeat (20) @(negedge clk);
        chk("idle_grant", 8'(g0), 8'h0);
        chk("idle_flag", 8'(f0), 8'h0);
        chk("idle_busy", 8'(b0), 8'h0);
        chk("idle_out_valid", 8'(ov0), 8'h0);

        // Single requester 2.
        req = 4'b0100; data = 4'b0100;
        @(negedge clk);
        chk("r2_grant", 8'(g0), 8'h04);
        chk("r2_sel", 8'(s0), 8'h2);
        chk("r2_flag", 8'(f0), 8'h1);
        chk("r2_valid_lag", 8'(ov0), 8'h0);
        @(negedge clk);
        chk("r2_out_data", 8'(od0), 8'h1);
        chk("r2_out_valid", 8'(ov0), 8'h1);
        repeat (2) @(negedge clk);
        chk("r2_grant_c4", 8'(g0), 8'h04);
        @(negedge clk);
        chk("r2_gap_grant", 8'(g0), 8'h0);
        chk("r2_gap_busy", 8'(b0), 8'h1);
        chk("r2_gap_valid", 8'(ov0), 8'h1);
        @(negedge clk);
        chk("r2_idle_busy", 8'(b0), 8'h0);
        chk("r2_idle_valid", 8'(ov0), 8'h0);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // All requesting: order 0,1,2,3,0.
        req = 4'b1111; data = 4'b1010;
        do_reset();
        capture(0, 5, 60);
        chk("all_0", 8'(onset[0]), 8'h01);
        chk("all_1", 8'(onset[1]), 8'h02);
        chk("all_2", 8'(onset[2]), 8'h04);
        chk("all_3", 8'(onset[3]), 8'h08);
        chk("all_4", 8'(onset[4]), 8'h01);

        // HOLD_CYCLES=1 alternation between 0 and 2.
        req = 4'b0101;
        do_reset();
        capture(1, 4, 30);
        chk("h1_0", 8'(onset[0]), 8'h01);
        chk("h1_1", 8'(onset[1]), 8'h04);
        chk("h1_2", 8'(onset[2]), 8'h01);
        chk("h1_3", 8'(onset[3]), 8'h04);

        // Owner 0 drops request in its second grant cycle.
        req = 4'b0011;
        do_reset();
        guard = 0;
        while (g0 != 4'b0001 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("drop_wait", 8'(g0), 8'h01);
        @(negedge clk);
        chk("drop_c2", 8'(g0), 8'h01);
        req = 4'b0010;
        @(negedge clk);
        chk("drop_end", 8'(g0), 8'h0);
        @(negedge clk);
        chk("drop_idle", 8'(g0), 8'h0);
        @(negedge clk);
        chk("drop_next", 8'(g0), 8'h02);

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            data = 4'($urandom);
        end

        // Asynchronous reset in the middle of a grant.
        req = 4'b1111;
        guard = 0;
        while (f0 != 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_wait", 8'(f0), 8'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_grant", 8'(g0), 8'h0);
        chk("async_flag", 8'(f0), 8'h0);
        chk("async_valid", 8'(ov0), 8'h0);
        chk("async_busy", 8'(b0), 8'h0);
        req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 8'(g0), 8'h08);
        chk("post_rst_sel", 8'(s0), 8'h3);

        req = 4'b0000;
        repeat (8) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_sched.md
# mux_rr_sched

Round-robin scheduler that shares the 4:1 gated bit selector (mux_latch) between four requesters. It arbitrates request lines, drives the selector's 2-bit select and enable flag, and bounds each grant to a fixed burst length. The selected bit is registered and presented with a valid strobe. The block sits between the requester logic and the serial output of the lab datapath.

## Interface
- HOLD_CYCLES, default 4: maximum consecutive cycles one requester may own the selector. Legal range is 1..15.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; bit i = requester i.
- data  input  4  data bit per requester; bit i is routed when requester i owns the selector.
- grant  output  4  one-hot current owner; all zero when nobody owns it.
- sel  output  2  select driven to the selector's valid input; binary index of owner.
- flag  output  1  selector enable; high exactly while grant is non-zero.
- out_data  output  1  registered selector output.
- out_valid  output  1  high when out_data carries a granted bit.
- busy  output  1  high in GRANT or GAP state.

## Operation
- FSM states: IDLE, GRANT, GAP. All outputs are registered.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise pick the winner: search from index (last+1) mod 4 upward, wrapping.
  - Load grant, sel, flag=1 and last=winner. Clear hold counter. Go to GRANT.
- GRANT: the hold counter increments each cycle. Leave to GAP on the first cycle where either condition holds:
  - req[owner] is low, or
  - counter == HOLD_CYCLES-1.
  - On leaving, clear grant, clear flag and hold sel.
- GAP: exactly one dead cycle with flag=0, then IDLE. This guarantees a switch-over bubble, so the selector never changes owner while enabled.
- Arbitration is evaluated only in IDLE. Requests arriving during GRANT or GAP wait.
- A requester that drops req while not granted loses nothing; there is no request queue.
- Fairness rule: after requester i is served, i has the lowest priority in the next arbitration. With all four requesting, service order from reset is 0,1,2,3,0,…
- The counter is a 4-bit unsigned value that saturates; it never wraps within a grant.
- The datapath is the instantiated selector:
  - sel drives its valid input and flag drives its flag input.
  - Its combinational output is registered into out_data.
  - out_valid <= flag on the same edge.
  - When flag is low, out_data <= 0.

## Timing
- Reset values: state=IDLE, grant=4'b0000, sel=2'b00, flag=0, out_data=0, out_valid=0, busy=0, counter=0, last=3. With last=3, the first search starts at requester 0.
- Request to grant latency: req sampled high in IDLE at edge t gives grant/flag high after edge t.
- Grant to data latency: out_data/out_valid lag flag by exactly one cycle. out_data reflects data[sel] as sampled at the edge where flag was high.
- Maximum grant length is HOLD_CYCLES cycles. The minimum gap between two grants is 2 cycles (GAP + IDLE).
- HOLD_CYCLES=1: each grant lasts one cycle.
- Owner drops req in the first GRANT cycle: the grant still lasts that one cycle, because flag was already registered high.
- Simultaneous release and timeout: treated as a single exit to GAP.
- rst_n asserted mid-grant: all outputs go to reset values immediately, without waiting for clk. The pointer resets to last=3.
- rst_n deassertion must be synchronised externally. The block does not change state on the first edge unless req is non-zero.

## Structure
- Shared include/package mux_sched_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2;
  - N_REQ=4;
  - the default HOLD_CYCLES.
- Sub-module rr_pick4: combinational round-robin picker. Inputs req[3:0] and last[1:0]; outputs any, idx[1:0] and onehot[3:0].
- The top level holds the FSM, the counter, the output registers and the selector instance.

## Test plan
- Reset, then req=4'b0100, data=4'b0100: grant=4'b0100, sel=2 and flag=1 one cycle after req. out_data=1 with out_valid=1 one cycle later. The grant lasts 4 cycles, then GAP.
- req=4'b1111 held with HOLD_CYCLES=4: grants go to 0,1,2,3,0 in order. Each lasts 4 cycles, separated by 2 cycles of flag=0.
- req=4'b0011; drop req[0] in its 2nd grant cycle: grant ends that cycle. The next grant goes to requester 1 after 2 idle cycles.
- Assert rst_n=0 mid-grant, between clock edges: grant, flag and out_valid go to 0 asynchronously. After release with req=4'b1000, requester 3 is granted.
- HOLD_CYCLES=1 with req=4'b0101: grants alternate 0,2,0,2, each 1 cycle wide.
- req=0 for 20 cycles after reset: all outputs remain at reset values and busy=0.
